lfsr_seq_checker: RTL and testbench
===================================

// Module: lfsr_seq_checker
// PURPOSE
//  Receive-side checker for the 8-bit pseudo-random weight stream produced by LFSRM1.
//  Self-synchronises its own predictor from the incoming samples, declares lock, then
//  counts mismatching samples. Used on the hidden-layer weight path of the ELM datapath
//  and in benches to prove the generator stays on-sequence across enable/restart gaps.
// PARAMETERS
//  TAPS      8'hB8  feedback mask; fb = ^(state & TAPS); next = {state[6:0], fb}
//  LOCK_CNT  4      consecutive matching samples required to enter LOCKED (1..15)
//  LOSS_CNT  3      consecutive mismatches in LOCKED that drop back to HUNT (1..15)
//  CNT_W     16     width of err_cnt and smp_cnt
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous, active-high global reset
//  rst_chk    in   1      synchronous checker restart: same effect as rst
//  en_chk     in   1      checker enable; samples ignored while low
//  in_data    in   8      LFSR sample (connect to LFSRM1 out)
//  in_valid   in   1      in_data carries a new sample this cycle
//  locked     out  1      predictor synchronised (state LOCKED)
//  err        out  1      one-cycle pulse: mismatch while LOCKED
//  err_cnt    out  CNT_W  mismatches counted while LOCKED, saturating
//  smp_cnt    out  CNT_W  samples checked while LOCKED, saturating
// BEHAVIOUR
//  - Accepted sample: en_chk & in_valid on a rising edge. All outputs are registered,
//    so each output reflects an accepted sample one cycle after acceptance.
//  - rst or rst_chk: state=HUNT, pred=8'h00, match/miss run counters=0, locked=0, err=0,
//    err_cnt=0, smp_cnt=0. Reset wins over any same-cycle sample.
//  - en_chk low: state, counters and pred hold; err forced 0. Gaps in in_valid do not
//    advance pred, so the checker follows a gated generator.
//  - HUNT: an accepted sample s != 8'h00 loads pred=next(s) and run=1, then goes to VERIFY.
//    If LOCK_CNT==1, it goes directly to LOCKED. s==8'h00 is illegal for the LFSR and is ignored.
//  - VERIFY: accepted s==pred -> pred=next(pred), run++. When run reaches LOCK_CNT -> LOCKED.
//    s!=pred -> re-seed exactly as in HUNT from s (run=1, stay VERIFY), or go to HUNT if s==0.
//  - LOCKED: every accepted sample increments smp_cnt. s==pred -> pred=next(pred),
//    miss run=0. s!=pred -> err=1 for one cycle, err_cnt++, pred=next(pred); the predictor
//    free-runs and does not re-seed from bad data, so single-sample corruption costs one error.
//    On the LOSS_CNT-th consecutive mismatch: state=HUNT, locked=0.
//    err_cnt and smp_cnt keep their values until reset.
//  - locked=1 exactly while state==LOCKED.
//  - Counters saturate at all-ones and do not wrap.
//  - Generator restart (LFSRM1 rst_lfsr) seen while LOCKED shows as mismatches. After
//    LOSS_CNT of them the checker re-hunts and relocks on the new phase within
//    LOSS_CNT+LOCK_CNT samples.
//  - next() is pure combinational on 8 bits. No arithmetic wider than CNT_W.
// TESTING  (TAPS=8'hB8: 01->02->04->08->11->23->47->8E...)
//  1 rst high 3 cycles -> locked=0, err=0, err_cnt=0, smp_cnt=0. Samples offered during rst are ignored.
//  2 feed 01,02,04,08 valid back-to-back -> locked rises 1 cycle after 08. Then feed 11,23
//    -> smp_cnt=2, err never pulses.
//  3 locked, feed 47 then 55 (expected 8E) then 1C -> single err pulse, err_cnt=1, locked
//    stays 1 (1C = next(8E)).
//  4 locked, feed three wrong samples in a row -> err_cnt+=3, locked falls after the 3rd.
//    Then 4 correct consecutive samples from any phase -> relock.
//  5 drop en_chk and in_valid for 10 cycles mid-sequence, then resume the next value
//    -> no err, pred held. Assert rst_chk mid-stream -> all outputs clear next cycle.
//  6 HUNT, feed 00,00,01 -> 00 ignored, seeding from 01. Force err_cnt near all-ones
//    (CNT_W=4 build) -> saturates at 4'hF.
//  7 connect LFSRM1 (en/rst_lfsr toggled as in its bench) -> lock, errors only at generator restart.

Source files
------------

// File: rtl/lfsr_seq_checker.sv
// Receive-side checker for an 8-bit Fibonacci LFSR stream: self-seeds a predictor,
// locks after a run of matches, then counts mismatching samples while locked.
module lfsr_seq_checker #(
    parameter logic [7:0]  TAPS     = 8'hB8,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rst_chk,
    input  logic             en_chk,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] smp_cnt
);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_V = 4'(LOSS_CNT);

    state_t           state, state_n;
    logic [7:0]       pred, pred_n;
    logic [3:0]       run, run_n;
    logic [3:0]       miss, miss_n;
    logic             err_n;
    logic [CNT_W-1:0] err_cnt_n, smp_cnt_n;
    logic [3:0]       run_inc, miss_inc;
    logic             accept;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & TAPS)};
    endfunction

    assign accept   = en_chk & in_valid;
    assign run_inc  = run + 4'd1;
    assign miss_inc = miss + 4'd1;
    assign locked   = (state == LOCKED);

    always_comb begin
        state_n   = state;
        pred_n    = pred;
        run_n     = run;
        miss_n    = miss;
        err_n     = 1'b0;
        err_cnt_n = err_cnt;
        smp_cnt_n = smp_cnt;
        if (accept) begin
            case (state)
                HUNT: begin
                    if (in_data != 8'h00) begin
                        pred_n  = lfsr_next(in_data);
                        run_n   = 4'd1;
                        miss_n  = '0;
                        state_n = (LOCK_V == 4'd1) ? LOCKED : VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_data == pred) begin
                        pred_n = lfsr_next(pred);
                        run_n  = run_inc;
                        if (run_inc == LOCK_V) begin
                            state_n = LOCKED;
                            miss_n  = '0;
                        end
                    end else if (in_data != 8'h00) begin
                        pred_n  = lfsr_next(in_data);
                        run_n   = 4'd1;
                        state_n = (LOCK_V == 4'd1) ? LOCKED : VERIFY;
                    end else begin
                        run_n   = '0;
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    // Predictor free-runs: bad samples never re-seed it.
                    pred_n = lfsr_next(pred);
                    if (smp_cnt != '1) smp_cnt_n = smp_cnt + CNT_W'(1);
                    if (in_data == pred) begin
                        miss_n = '0;
                    end else begin
                        err_n = 1'b1;
                        if (err_cnt != '1) err_cnt_n = err_cnt + CNT_W'(1);
                        if (miss_inc == LOSS_V) begin
                            miss_n  = '0;
                            run_n   = '0;
                            state_n = HUNT;
                        end else begin
                            miss_n = miss_inc;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || rst_chk) begin
            state   <= HUNT;
            pred    <= 8'h00;
            run     <= '0;
            miss    <= '0;
            err     <= 1'b0;
            err_cnt <= '0;
            smp_cnt <= '0;
        end else begin
            state   <= state_n;
            pred    <= pred_n;
            run     <= run_n;
            miss    <= miss_n;
            err     <= err_n;
            err_cnt <= err_cnt_n;
            smp_cnt <= smp_cnt_n;
        end
    end

endmodule

// File: tb/tb_lfsr_seq_checker.sv
// Table-driven bench for lfsr_seq_checker with a scoreboard queue, a saturation run on a
// narrow-counter instance, and a gated/restarted generator model feeding the checker.
module tb_lfsr_seq_checker;

    typedef struct {
        logic        rst;
        logic        rst_chk;
        logic        en;
        logic        valid;
        logic [7:0]  data;
        logic        locked;
        logic        err;
        logic [15:0] ecnt;
        logic [15:0] scnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_chk = 1'b0;
    logic        en_chk = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        locked, err, locked4, err4;
    logic [15:0] err_cnt, smp_cnt;
    logic [3:0]  err_cnt4, smp_cnt4;

    int n_vec = 0;
    int n_bad = 0;
    vec_t tab[$];
    vec_t sb[$];

    lfsr_seq_checker #(.TAPS(8'hB8), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rst_chk(rst_chk), .en_chk(en_chk), .in_data(in_data),
        .in_valid(in_valid), .locked(locked), .err(err), .err_cnt(err_cnt), .smp_cnt(smp_cnt)
    );

    lfsr_seq_checker #(.TAPS(8'hB8), .LOCK_CNT(4), .LOSS_CNT(3), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .rst_chk(rst_chk), .en_chk(en_chk), .in_data(in_data),
        .in_valid(in_valid), .locked(locked4), .err(err4), .err_cnt(err_cnt4), .smp_cnt(smp_cnt4)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] nx(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic vec_t mk(input logic r, input logic rc, input logic en, input logic v,
                                input logic [7:0] d, input logic l, input logic e,
                                input logic [15:0] ec, input logic [15:0] sc);
        vec_t t;
        t.rst = r; t.rst_chk = rc; t.en = en; t.valid = v; t.data = d;
        t.locked = l; t.err = e; t.ecnt = ec; t.scnt = sc;
        return t;
    endfunction

    task automatic check_out();
        vec_t e;
        e = sb.pop_front();
        n_vec++;
        if (locked !== e.locked) begin
            n_bad++;
            $display("FAIL vec%0d locked: got %b want %b", n_vec, locked, e.locked);
        end
        if (err !== e.err) begin
            n_bad++;
            $display("FAIL vec%0d err: got %b want %b", n_vec, err, e.err);
        end
        if (err_cnt !== e.ecnt) begin
            n_bad++;
            $display("FAIL vec%0d err_cnt: got %0d want %0d", n_vec, err_cnt, e.ecnt);
        end
        if (smp_cnt !== e.scnt) begin
            n_bad++;
            $display("FAIL vec%0d smp_cnt: got %0d want %0d", n_vec, smp_cnt, e.scnt);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic apply(input vec_t v);
        rst = v.rst; rst_chk = v.rst_chk; en_chk = v.en; in_valid = v.valid; in_data = v.data;
        sb.push_back(v);
        @(posedge clk);
        #1;
        check_out();
        @(negedge clk);
    endtask

    task automatic chk4(input int n_err, input int n_smp);
        logic [3:0] we, ws;
        we = (n_err > 15) ? 4'hF : 4'(n_err);
        ws = (n_smp > 15) ? 4'hF : 4'(n_smp);
        n_vec++;
        if (err_cnt4 !== we || smp_cnt4 !== ws) begin
            n_bad++;
            $display("FAIL sat4 cnt: got err_cnt=%h smp_cnt=%h want %h %h", err_cnt4, smp_cnt4, we, ws);
        end
    endtask

    initial begin
        int   k, m, base;
        logic v;
        logic [7:0] g;

        // reset, samples offered during reset ignored
        tab.push_back(mk(1, 0, 1, 1, 8'h01, 0, 0, 0, 0));
        tab.push_back(mk(1, 0, 1, 1, 8'h02, 0, 0, 0, 0));
        tab.push_back(mk(1, 0, 1, 1, 8'h04, 0, 0, 0, 0));
        // acquire lock
        tab.push_back(mk(0, 0, 1, 1, 8'h01, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h02, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h04, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h08, 1, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h11, 1, 0, 0, 1));
        tab.push_back(mk(0, 0, 1, 1, 8'h23, 1, 0, 0, 2));
        // single corrupted sample
        tab.push_back(mk(0, 0, 1, 1, 8'h47, 1, 0, 0, 3));
        tab.push_back(mk(0, 0, 1, 1, 8'h55, 1, 1, 1, 4));
        tab.push_back(mk(0, 0, 1, 1, 8'h1C, 1, 0, 1, 5));
        // three wrong in a row -> loss of lock, then relock on another phase
        tab.push_back(mk(0, 0, 1, 1, 8'hFF, 1, 1, 2, 6));
        tab.push_back(mk(0, 0, 1, 1, 8'hFF, 1, 1, 3, 7));
        tab.push_back(mk(0, 0, 1, 1, 8'hFF, 0, 1, 4, 8));
        tab.push_back(mk(0, 0, 1, 1, 8'h47, 0, 0, 4, 8));
        tab.push_back(mk(0, 0, 1, 1, 8'h8E, 0, 0, 4, 8));
        tab.push_back(mk(0, 0, 1, 1, 8'h1C, 0, 0, 4, 8));
        tab.push_back(mk(0, 0, 1, 1, 8'h38, 1, 0, 4, 8));
        // gap: garbage with either en_chk or in_valid low is ignored
        for (int i = 0; i < 10; i++)
            tab.push_back(mk(0, 0, 1'(i % 2), 1'((i + 1) % 2), 8'hFF, 1, 0, 4, 8));
        tab.push_back(mk(0, 0, 1, 1, 8'h71, 1, 0, 4, 9));
        tab.push_back(mk(0, 0, 1, 1, 8'hE2, 1, 0, 4, 10));
        tab.push_back(mk(0, 1, 1, 1, 8'hC4, 0, 0, 0, 0));
        // zeros ignored in HUNT, seeding from 01
        tab.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h00, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h01, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h02, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h04, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h08, 1, 0, 0, 0));
        // mismatch in VERIFY re-seeds from the bad sample
        tab.push_back(mk(0, 1, 1, 1, 8'h00, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h01, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h02, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h47, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h8E, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h1C, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 1, 1, 8'h38, 1, 0, 0, 0));

        @(negedge clk);
        foreach (tab[i]) apply(tab[i]);

        // saturation on the 4-bit counter build: 6 rounds of lock + 3 errors
        apply(mk(1, 0, 1, 1, 8'h00, 0, 0, 0, 0));
        chk4(0, 0);
        for (int r = 0; r < 6; r++) begin
            base = 3 * r;
            apply(mk(0, 0, 1, 1, 8'h01, 0, 0, 16'(base), 16'(base)));
            apply(mk(0, 0, 1, 1, 8'h02, 0, 0, 16'(base), 16'(base)));
            apply(mk(0, 0, 1, 1, 8'h04, 0, 0, 16'(base), 16'(base)));
            apply(mk(0, 0, 1, 1, 8'h08, 1, 0, 16'(base), 16'(base)));
            for (int j = 1; j <= 3; j++) begin
                apply(mk(0, 0, 1, 1, 8'hFF, 1'(j < 3), 1, 16'(base + j), 16'(base + j)));
                chk4(base + j, base + j);
            end
        end

        // gated generator: lock and stay clean across valid gaps
        apply(mk(1, 0, 1, 0, 8'h00, 0, 0, 0, 0));
        g = 8'h01;
        k = 0;
        for (int c = 0; c < 400 && k < 20; c++) begin
            v = ($urandom_range(3) != 0);
            if (v) k++;
            apply(mk(0, 0, 1, v, v ? g : 8'hA5, k >= 4, 0, 0, (k > 4) ? 16'(k - 4) : 16'd0));
            if (v) g = nx(g);
        end
        n_vec++;
        if (k != 20) begin
            n_bad++;
            $display("FAIL gen_budget: got %0d samples want 20", k);
        end

        // generator restart while locked: 3 errors, re-hunt, relock within 7 samples
        g = 8'h01;
        m = 0;
        for (int c = 0; c < 400 && m < 12; c++) begin
            v = ($urandom_range(3) != 0);
            if (v) m++;
            apply(mk(0, 0, 1, v, v ? g : 8'h5A,
                     (m < 3) || (m >= 7),
                     v && (m >= 1) && (m <= 3),
                     (m >= 3) ? 16'd3 : 16'(m),
                     16'(16 + ((m <= 3) ? m : ((m <= 7) ? 3 : 3 + (m - 7))))));
            if (v) g = nx(g);
        end
        n_vec++;
        if (m != 12) begin
            n_bad++;
            $display("FAIL restart_budget: got %0d samples want 12", m);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
